// File: rtl/arr_stim_pkg.sv
// Shared types and constants for the arr_stim stimulus family.
// Also holds the LFSR step and seed helpers used by the top and by arr_stim_lfsr.
package arr_stim_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } arr_stim_state_t;

  localparam logic [31:0] LFSR_POLY = 32'h80200003;
  localparam int          CNT_W     = 16;

  // One Galois step, shifting right.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  function automatic logic [31:0] seed_fix(input logic [31:0] s);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

endpackage

// File: rtl/arr_stim_lfsr.sv
// 32-bit Galois LFSR with synchronous load-to-seed and advance controls.
// Reset and load both restore the (zero-remapped) SEED.
module arr_stim_lfsr
  import arr_stim_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        advance,
  output logic [31:0] state
);

  localparam logic [31:0] SEED_EFF = seed_fix(SEED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEED_EFF;
    end else if (load) begin
      state <= SEED_EFF;
    end else if (advance) begin
      state <= lfsr_step(state);
    end
  end

endmodule

// File: rtl/arr_stim.sv
// Burst stimulus source for one arr checker: emits LFSR vector pairs on sig0/sig1.
// Optional sig1 bit-0 corruption is compiled in with ARR_STIM_INJECT_EN.
//
// state | meaning
// IDLE  | waiting for start; sig0 == sig1
// RUN   | emitting one vector per cycle
// DONE  | one-cycle done pulse, then IDLE
module arr_stim
  import arr_stim_pkg::*;
#(
  parameter int          LENGTH = 1,
  parameter logic [31:0] SEED   = 32'h1
) (
  input  logic              arr_stim_clk_ip,
  input  logic              arr_stim_rst_n_ip,
  input  logic              arr_stim_start_ip,
  input  logic [CNT_W-1:0]  arr_stim_count_ip,
  input  logic [CNT_W-1:0]  arr_stim_inj_period_ip,
  output logic [LENGTH-1:0] arr_stim_sig0_op,
  output logic [LENGTH-1:0] arr_stim_sig1_op,
  output logic              arr_stim_vld_op,
  output logic              arr_stim_busy_op,
  output logic              arr_stim_done_op,
  output logic [CNT_W-1:0]  arr_stim_inj_cnt_op
);

  localparam logic [31:0] SEED_EFF = seed_fix(SEED);

  function automatic logic [LENGTH-1:0] rep(input logic [31:0] s);
    logic [LENGTH-1:0] r;
    for (int i = 0; i < LENGTH; i++) begin
      r[i] = s[i[4:0]];
    end
    return r;
  endfunction

  arr_stim_state_t   state_q;
  logic [CNT_W-1:0]  rem_q;
  logic [LENGTH-1:0] sig0_q, sig1_q;
  logic              vld_q, busy_q, done_q;
  logic [31:0]       lfsr_q;
  logic [31:0]       emit_val;
  logic              lfsr_load, lfsr_adv, emitting, corrupt;

  assign lfsr_load = (state_q == IDLE) && arr_stim_start_ip && (arr_stim_count_ip != '0);
  assign lfsr_adv  = (state_q == RUN) && (rem_q != '0);
  assign emitting  = lfsr_load | lfsr_adv;
  // The LFSR always holds the vector currently on sig0, so the next one is one step ahead.
  assign emit_val  = lfsr_load ? SEED_EFF : lfsr_step(lfsr_q);

  arr_stim_lfsr #(.SEED(SEED)) u_lfsr (
    .clk     (arr_stim_clk_ip),
    .rst_n   (arr_stim_rst_n_ip),
    .load    (lfsr_load),
    .advance (lfsr_adv),
    .state   (lfsr_q)
  );

  always_ff @(posedge arr_stim_clk_ip or negedge arr_stim_rst_n_ip) begin
    if (!arr_stim_rst_n_ip) begin
      state_q <= IDLE;
      rem_q   <= '0;
      sig0_q  <= '0;
      sig1_q  <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (arr_stim_start_ip) begin
            if (arr_stim_count_ip != '0) begin
              state_q <= RUN;
              rem_q   <= arr_stim_count_ip - 1'b1;
              vld_q   <= 1'b1;
              busy_q  <= 1'b1;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (rem_q == '0) begin
            state_q <= DONE;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            rem_q <= rem_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (emitting) begin
        sig0_q <= rep(emit_val);
        sig1_q <= rep(emit_val) ^ LENGTH'(corrupt);
      end else begin
        sig1_q <= sig0_q;
      end
    end
  end

`ifdef ARR_STIM_INJECT_EN
  logic [CNT_W-1:0] per_q, dn_q, inj_cnt_q;

  // Vector i is hit when (i+1) is a multiple of the period; dn_q counts down to that point.
  always_comb begin
    corrupt = 1'b0;
    if (lfsr_load) begin
      corrupt = (arr_stim_inj_period_ip == CNT_W'(1));
    end else if (lfsr_adv) begin
      corrupt = (per_q != '0) && (dn_q == CNT_W'(1));
    end
  end

  always_ff @(posedge arr_stim_clk_ip or negedge arr_stim_rst_n_ip) begin
    if (!arr_stim_rst_n_ip) begin
      per_q     <= '0;
      dn_q      <= '0;
      inj_cnt_q <= '0;
    end else if (lfsr_load) begin
      per_q     <= arr_stim_inj_period_ip;
      dn_q      <= corrupt ? arr_stim_inj_period_ip : arr_stim_inj_period_ip - 1'b1;
      inj_cnt_q <= corrupt ? CNT_W'(1) : '0;
    end else if (lfsr_adv) begin
      dn_q <= (dn_q == CNT_W'(1)) ? per_q : dn_q - 1'b1;
      if (corrupt && (inj_cnt_q != '1)) begin
        inj_cnt_q <= inj_cnt_q + 1'b1;
      end
    end
  end

  assign arr_stim_inj_cnt_op = inj_cnt_q;
`else
  logic unused_period;
  assign unused_period       = ^arr_stim_inj_period_ip;
  assign corrupt             = 1'b0;
  assign arr_stim_inj_cnt_op = '0;
`endif

  assign arr_stim_sig0_op = sig0_q;
  assign arr_stim_sig1_op = sig1_q;
  assign arr_stim_vld_op  = vld_q;
  assign arr_stim_busy_op = busy_q;
  assign arr_stim_done_op = done_q;

endmodule

// File: tb/tb_arr_stim.sv
// Directed self-checking bench for arr_stim at LENGTH 8, 1 and 255 driven in parallel.
// Expectations follow ARR_STIM_INJECT_EN when it is defined for the build.
module tb_arr_stim;

`ifdef ARR_STIM_INJECT_EN
  localparam bit INJ = 1'b1;
`else
  localparam bit INJ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] count, inj_period;

  logic [7:0]   s0_8, s1_8;
  logic [0:0]   s0_1, s1_1;
  logic [254:0] s0_w, s1_w;
  logic         vld_8, busy_8, done_8, vld_1, busy_1, done_1, vld_w, busy_w, done_w;
  logic [15:0]  ic_8, ic_1, ic_w;

  int checks = 0;
  int errors = 0;

  // Seed 1 sequence, worked by hand: s' = (s >> 1) ^ (s[0] ? 32'h80200003 : 0).
  logic [31:0] vec [10] = '{32'h00000001, 32'h80200003, 32'hC0300002, 32'h60180001,
                            32'hB02C0003, 32'hD8360002, 32'h6C1B0001, 32'hB62D8003,
                            32'hDB36C002, 32'h6D9B6001};

  always #5 clk = ~clk;

  arr_stim #(.LENGTH(8), .SEED(32'h1)) u8 (
    .arr_stim_clk_ip(clk), .arr_stim_rst_n_ip(rst_n), .arr_stim_start_ip(start),
    .arr_stim_count_ip(count), .arr_stim_inj_period_ip(inj_period),
    .arr_stim_sig0_op(s0_8), .arr_stim_sig1_op(s1_8), .arr_stim_vld_op(vld_8),
    .arr_stim_busy_op(busy_8), .arr_stim_done_op(done_8), .arr_stim_inj_cnt_op(ic_8));

  arr_stim #(.LENGTH(1), .SEED(32'h0)) u1 (
    .arr_stim_clk_ip(clk), .arr_stim_rst_n_ip(rst_n), .arr_stim_start_ip(start),
    .arr_stim_count_ip(count), .arr_stim_inj_period_ip(inj_period),
    .arr_stim_sig0_op(s0_1), .arr_stim_sig1_op(s1_1), .arr_stim_vld_op(vld_1),
    .arr_stim_busy_op(busy_1), .arr_stim_done_op(done_1), .arr_stim_inj_cnt_op(ic_1));

  arr_stim #(.LENGTH(255), .SEED(32'h1)) uw (
    .arr_stim_clk_ip(clk), .arr_stim_rst_n_ip(rst_n), .arr_stim_start_ip(start),
    .arr_stim_count_ip(count), .arr_stim_inj_period_ip(inj_period),
    .arr_stim_sig0_op(s0_w), .arr_stim_sig1_op(s1_w), .arr_stim_vld_op(vld_w),
    .arr_stim_busy_op(busy_w), .arr_stim_done_op(done_w), .arr_stim_inj_cnt_op(ic_w));

  function automatic logic [254:0] rep255(input logic [31:0] s);
    logic [255:0] t;
    t = {8{s}};
    return t[254:0];
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag, input logic [7:0] exp_sig0);
    chk({tag, "_vld"},  {vld_8, vld_1, vld_w},    3'b000);
    chk({tag, "_busy"}, {busy_8, busy_1, busy_w}, 3'b000);
    chk({tag, "_sig0"}, s0_8, exp_sig0);
    chk({tag, "_eq"},   {s1_8 == s0_8, s1_1 == s0_1, s1_w == s0_w}, 3'b111);
  endtask

  // Launches a burst from the current negedge and checks every vector, the done cycle and the idle cycle.
  task automatic burst(input int cnt, input int per, input bit repulse, input string tag);
    int          ninj = 0;
    logic [31:0] v;
    bit          cor;
    count      = 16'(cnt);
    inj_period = 16'(per);
    start      = 1'b1;
    for (int i = 0; i < cnt; i++) begin
      @(posedge clk);
      @(negedge clk);
      start = repulse && (i < cnt - 1);
      v   = vec[i];
      cor = INJ && (per != 0) && (((i + 1) % per) == 0);
      if (cor) ninj++;
      chk($sformatf("%s_v%0d_ctl", tag, i),
          {vld_8, busy_8, done_8, vld_1, busy_1, done_1, vld_w, busy_w, done_w}, 9'b110_110_110);
      chk($sformatf("%s_v%0d_sig0_8", tag, i), s0_8, v[7:0]);
      chk($sformatf("%s_v%0d_sig1_8", tag, i), s1_8, v[7:0] ^ {7'b0, cor});
      chk($sformatf("%s_v%0d_sig_1", tag, i), {s0_1, s1_1}, {v[0], v[0] ^ cor});
      chk($sformatf("%s_v%0d_sig0_w", tag, i), s0_w, rep255(v));
      chk($sformatf("%s_v%0d_sig1_w", tag, i), s1_w, rep255(v) ^ {254'b0, cor});
      chk($sformatf("%s_v%0d_inj", tag, i), {ic_8, ic_1, ic_w}, {3{16'(ninj)}});
    end
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_done"}, {done_8, done_1, done_w}, 3'b111);
    chk_quiet({tag, "_donecyc"}, vec[cnt-1][7:0]);
    chk({tag, "_inj_final"}, ic_8, 16'(ninj));
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_done_drop"}, {done_8, done_1, done_w}, 3'b000);
    chk_quiet({tag, "_idle"}, vec[cnt-1][7:0]);
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    count      = 16'd0;
    inj_period = 16'd0;
    repeat (2) @(negedge clk);
    chk("rst_ctl", {vld_8, busy_8, done_8, vld_w, busy_w, done_w}, 6'b0);
    chk("rst_sig", {s0_8, s1_8, s0_1, s1_1}, 18'b0);
    chk("rst_sig_w", {s0_w, s1_w}, 510'b0);
    chk("rst_inj", {ic_8, ic_1, ic_w}, 48'b0);
    rst_n = 1'b1;
    @(negedge clk);

    burst(4, 0, 1'b0, "b4");

    // Zero-length burst: done only.
    count = 16'd0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("c0_done", {done_8, done_1, done_w}, 3'b111);
    chk_quiet("c0", 8'h01);
    chk("c0_inj", ic_8, 16'd0);
    @(posedge clk);
    @(negedge clk);
    chk("c0_done_drop", {done_8, done_1, done_w}, 3'b000);
    chk_quiet("c0_after", 8'h01);

    burst(10, 3, 1'b0, "inj");
    burst(4, 0, 1'b1, "repulse");
    burst(4, 0, 1'b0, "again");
    burst(3, 1, 1'b0, "p1");

    // Reset at vector 5 of a 20-vector burst.
    count      = 16'd20;
    inj_period = 16'd3;
    start      = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("mid_v%0d", i), {vld_8, s0_8}, {1'b1, vec[i][7:0]});
    end
    chk("mid_inj", ic_8, INJ ? 16'd2 : 16'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ctl", {vld_8, busy_8, done_8, vld_w, busy_w, done_w}, 6'b0);
    chk("mid_rst_sig", {s0_8, s1_8, s0_1, s1_1}, 18'b0);
    chk("mid_rst_inj", {ic_8, ic_1, ic_w}, 48'b0);
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_nodone", {done_8, done_1, done_w, vld_8}, 4'b0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rel_nodone", {done_8, done_1, done_w, busy_8}, 4'b0);

    burst(4, 0, 1'b0, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
